// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: sequential fetch, one request outstanding, in-order queue to decoder.
// Optional IFU_BYPASS_EN: forward a response straight to the decoder when the queue is empty.
module ifu_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          drop_q, drop_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   word_q [DEPTH];

    logic fire;
    logic rsp;
    logic has;
    logic byp;
    logic push;
    logic pop;

    assign has  = (count_q != '0);
    assign rsp  = im_rvalid && outstanding_q;
    assign fire = im_req && im_gnt;

    assign im_req  = !rst && !redirect && !outstanding_q && (count_q < DEPTH_C);
    assign im_addr = fetch_pc_q;

`ifdef IFU_BYPASS_EN
    assign byp = !has && !drop_q && rsp && !redirect;
`else
    assign byp = 1'b0;
`endif

    // A bypassed word taken by the decoder this cycle never enters the queue
    assign push = rsp && !drop_q && !redirect && !(byp && instr_ready);
    assign pop  = has && instr_ready && !redirect;

    always_comb begin
        instr_valid = has || byp;
        instr       = '0;
        instr_pc    = '0;
        if (has) begin
            instr    = word_q[rd_ptr_q];
            instr_pc = pc_q[rd_ptr_q];
        end else if (byp) begin
            instr    = im_rdata;
            instr_pc = req_pc_q;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            if (rsp) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end else if (outstanding_q) begin
                drop_d = 1'b1;
            end
        end else begin
            if (fire) begin
                outstanding_d = 1'b1;
                req_pc_d      = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            if (rsp) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_q[wr_ptr_q]   <= req_pc_q;
            word_q[wr_ptr_q] <= im_rdata;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: vector table plus redirect/reset/bypass sequences.
module tb_ifu_fetch_queue;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks;
    int failures;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    ifu_fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_gnt     (im_gnt),
        .im_rvalid  (im_rvalid),
        .im_rdata   (im_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic g, input logic rv,
                       input logic [31:0] rd, input logic rdy,
                       input logic eq, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep);
        vec_t t;
        t.rst = r; t.gnt = g; t.rv = rv; t.rdata = rd; t.rdy = rdy;
        t.e_req = eq; t.e_addr = ea; t.e_v = ev; t.e_ins = ei; t.e_pc = ep;
        vecs.push_back(t);
    endtask

    // Drive on the falling edge, then settle before checking
    task automatic drive(input logic r, input logic g, input logic rv,
                         input logic [31:0] rd, input logic rdr,
                         input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst = r; im_gnt = g; im_rvalid = rv; im_rdata = rd;
        redirect = rdr; redirect_pc = rpc; instr_ready = rdy;
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eq,
                           input logic [31:0] ea, input logic ev,
                           input logic [31:0] ei, input logic [31:0] ep);
        chk({tag, ".im_req"}, {31'd0, im_req}, {31'd0, eq});
        chk({tag, ".im_addr"}, im_addr, ea);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, ev});
        chk({tag, ".instr"}, instr, ei);
        chk({tag, ".pc"}, instr_pc, ep);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; im_gnt = 0; im_rvalid = 0; im_rdata = 0;
        redirect = 0; redirect_pc = 0; instr_ready = 0;
        repeat (2) @(posedge clk);

`ifndef IFU_BYPASS_EN
        // Streaming with ready=1: one word every two cycles
        add(1,0,0,32'h0,          0, 0,32'h00400000, 0,32'h0,          32'h0);
        add(0,1,0,32'h0,          1, 1,32'h00400000, 0,32'h0,          32'h0);
        add(0,1,1,32'hC0DE0000,   1, 0,32'h00400004, 0,32'h0,          32'h0);
        add(0,1,0,32'h0,          1, 1,32'h00400004, 1,32'hC0DE0000,   32'h00400000);
        add(0,1,1,32'hC0DE0001,   1, 0,32'h00400008, 0,32'h0,          32'h0);
        add(0,1,0,32'h0,          1, 1,32'h00400008, 1,32'hC0DE0001,   32'h00400004);
        add(0,1,1,32'hC0DE0002,   1, 0,32'h0040000C, 0,32'h0,          32'h0);
        add(0,0,0,32'h0,          1, 1,32'h0040000C, 1,32'hC0DE0002,   32'h00400008);
        add(0,0,0,32'h0,          0, 1,32'h0040000C, 0,32'h0,          32'h0);
        // Fill with ready=0, stall at full, then drain
        add(1,0,0,32'h0,          0, 0,32'h0040000C, 0,32'h0,          32'h0);
        add(0,1,0,32'h0,          0, 1,32'h00400000, 0,32'h0,          32'h0);
        add(0,0,1,32'hB0000000,   0, 0,32'h00400004, 0,32'h0,          32'h0);
        add(0,1,0,32'h0,          0, 1,32'h00400004, 1,32'hB0000000,   32'h00400000);
        add(0,0,1,32'hB0000001,   0, 0,32'h00400008, 1,32'hB0000000,   32'h00400000);
        add(0,1,0,32'h0,          0, 1,32'h00400008, 1,32'hB0000000,   32'h00400000);
        add(0,0,1,32'hB0000002,   0, 0,32'h0040000C, 1,32'hB0000000,   32'h00400000);
        add(0,1,0,32'h0,          0, 1,32'h0040000C, 1,32'hB0000000,   32'h00400000);
        add(0,0,1,32'hB0000003,   0, 0,32'h00400010, 1,32'hB0000000,   32'h00400000);
        add(0,1,0,32'h0,          0, 0,32'h00400010, 1,32'hB0000000,   32'h00400000);
        add(0,1,0,32'h0,          0, 0,32'h00400010, 1,32'hB0000000,   32'h00400000);
        add(0,0,0,32'h0,          1, 0,32'h00400010, 1,32'hB0000000,   32'h00400000);
        add(0,0,0,32'h0,          1, 1,32'h00400010, 1,32'hB0000001,   32'h00400004);
        add(0,0,0,32'h0,          1, 1,32'h00400010, 1,32'hB0000002,   32'h00400008);
        add(0,0,0,32'h0,          1, 1,32'h00400010, 1,32'hB0000003,   32'h0040000C);
        add(0,1,0,32'h0,          0, 1,32'h00400010, 0,32'h0,          32'h0);
        add(0,0,1,32'hB0000004,   1, 0,32'h00400014, 0,32'h0,          32'h0);
        add(0,0,0,32'h0,          1, 1,32'h00400014, 1,32'hB0000004,   32'h00400010);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
                  1'b0, 32'h0, vecs[i].rdy);
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_v, vecs[i].e_ins, vecs[i].e_pc);
        end

        // Redirect while a request is outstanding: stale word dropped
        drive(0,1,0,32'h0,0,32'h0,0);
        chk_all("rd0", 1, 32'h00400014, 0, 0, 0);
        drive(0,0,0,32'h0,1,32'h00400103,1);
        chk_all("rd1", 0, 32'h00400018, 0, 0, 0);
        drive(0,1,0,32'h0,0,32'h0,1);
        chk_all("rd2", 0, 32'h00400100, 0, 0, 0);
        drive(0,0,1,32'hDEADDEAD,0,32'h0,1);
        chk_all("rd3", 0, 32'h00400100, 0, 0, 0);
        drive(0,1,0,32'h0,0,32'h0,1);
        chk_all("rd4", 1, 32'h00400100, 0, 0, 0);
        drive(0,0,1,32'h11110000,0,32'h0,1);
        chk_all("rd5", 0, 32'h00400104, 0, 0, 0);
        drive(0,0,0,32'h0,0,32'h0,1);
        chk_all("rd6", 1, 32'h00400104, 1, 32'h11110000, 32'h00400100);

        // Redirect together with a response and a pending pop
        drive(0,1,0,32'h0,0,32'h0,0);
        chk_all("rr0", 1, 32'h00400104, 0, 0, 0);
        drive(0,0,1,32'h55550005,0,32'h0,0);
        chk_all("rr1", 0, 32'h00400108, 0, 0, 0);
        drive(0,1,0,32'h0,0,32'h0,0);
        chk_all("rr2", 1, 32'h00400108, 1, 32'h55550005, 32'h00400104);
        drive(0,0,1,32'h55550006,1,32'h00400200,1);
        chk("rr3.im_req", {31'd0, im_req}, 32'd0);
        drive(0,0,0,32'h0,0,32'h0,1);
        chk_all("rr4", 1, 32'h00400200, 0, 0, 0);
        drive(0,1,0,32'h0,0,32'h0,1);
        chk_all("rr5", 1, 32'h00400200, 0, 0, 0);
        drive(0,0,0,32'h0,0,32'h0,1);
        chk_all("rr6", 0, 32'h00400204, 0, 0, 0);
        drive(0,0,1,32'h55550007,0,32'h0,1);
        chk_all("rr7", 0, 32'h00400204, 0, 0, 0);
        drive(0,0,0,32'h0,0,32'h0,1);
        chk_all("rr8", 1, 32'h00400204, 1, 32'h55550007, 32'h00400200);

        // Reset mid-fetch with a queued word, then a spurious response
        drive(0,1,0,32'h0,0,32'h0,0);
        chk_all("rs0", 1, 32'h00400204, 0, 0, 0);
        drive(0,0,1,32'h77770008,0,32'h0,0);
        drive(0,1,0,32'h0,0,32'h0,0);
        chk_all("rs1", 1, 32'h00400208, 1, 32'h77770008, 32'h00400204);
        drive(1,0,0,32'h0,0,32'h0,0);
        chk("rs2.im_req", {31'd0, im_req}, 32'd0);
        drive(0,0,1,32'h77770009,0,32'h0,1);
        chk_all("rs3", 1, 32'h00400000, 0, 0, 0);
        drive(0,0,0,32'h0,0,32'h0,1);
        chk_all("rs4", 1, 32'h00400000, 0, 0, 0);
`endif

        // Empty-queue response: same-cycle under bypass, next cycle otherwise
        drive(1,0,0,32'h0,0,32'h0,1);
        chk("by0.im_req", {31'd0, im_req}, 32'd0);
        drive(0,1,0,32'h0,0,32'h0,1);
        chk_all("by1", 1, 32'h00400000, 0, 0, 0);
        drive(0,0,1,32'h8C080004,0,32'h0,1);
`ifdef IFU_BYPASS_EN
        chk_all("by2", 0, 32'h00400004, 1, 32'h8C080004, 32'h00400000);
        drive(0,0,0,32'h0,0,32'h0,1);
        chk_all("by3", 1, 32'h00400004, 0, 0, 0);
`else
        chk_all("by2", 0, 32'h00400004, 0, 0, 0);
        drive(0,0,0,32'h0,0,32'h0,1);
        chk_all("by3", 1, 32'h00400004, 1, 32'h8C080004, 32'h00400000);
        drive(0,0,0,32'h0,0,32'h0,1);
        chk_all("by4", 1, 32'h00400004, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Instruction fetch unit for the 31-instruction MIPS core. It generates sequential fetch addresses and requests words from instruction memory with one request outstanding at a time. Returned words go into a small in-order queue that feeds the instruction decoder/controller through a valid/ready handshake, together with each word's PC. A branch or jump redirect flushes the queue, discards any in-flight response, and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h0040_0000, fetch address loaded on reset
- DEPTH, 4, queue entries; power of two, ≥ 2

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- im_req  out  1  fetch request to instruction memory
- im_addr  out  32  word-aligned fetch address; valid while im_req
- im_gnt  in  1  memory accepts request this cycle; ignored when im_req=0
- im_rvalid  in  1  response data valid; at least 1 cycle after im_gnt
- im_rdata  in  32  fetched instruction word
- redirect  in  1  flush and restart fetch (taken branch/jump, from control)
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0
- instr_valid  out  1  instr/instr_pc hold the oldest queued instruction
- instr  out  32  instruction word to the decoder; 0 when instr_valid=0
- instr_pc  out  32  PC of instr; 0 when instr_valid=0
- instr_ready  in  1  decoder consumes instr this cycle

## Operation
- State: fetch_pc (32), outstanding (1), drop (1), queue (DEPTH × {pc, word}), rd_ptr, wr_ptr, count (log2(DEPTH)+1 bits).
- im_req = !rst && !redirect && !outstanding && (count < DEPTH). This is combinational from registered state plus redirect.
- im_addr = fetch_pc at all times.
- On im_req && im_gnt:
  - outstanding ← 1.
  - The request's PC is latched as req_pc.
  - fetch_pc ← fetch_pc + 4, wrapping modulo 2^32.
- On im_rvalid:
  - outstanding ← 0.
  - If drop=0, push {req_pc, im_rdata}; otherwise discard the word and set drop ← 0.
- Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle: count is unchanged.
  - Pop of the last entry with a simultaneous push: the new entry becomes the head on the next cycle.
- The reservation rule (count + outstanding ≤ DEPTH) guarantees a push never overflows.
- Redirect has priority over all other events in its cycle:
  - Queue is cleared (count, rd_ptr, wr_ptr ← 0); a pop in the same cycle is ignored.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - If outstanding=1 and im_rvalid=0 that cycle: drop ← 1.
  - If im_rvalid=1 that cycle: the response is discarded and outstanding ← 0.
- im_rvalid with outstanding=0 is a protocol error. It is ignored and nothing is pushed.

## Timing
- Reset values: im_req 0 (during rst), im_addr = RESET_PC, instr_valid 0, instr 0, instr_pc 0, outstanding 0, drop 0, count 0.
- First im_req is asserted in the first cycle after rst deasserts.
- Issue rate: one request per response. A new request can be issued at the earliest the cycle after im_rvalid.
- Default latency: a word pushed on im_rvalid is presented on instr the next cycle.
- Redirect: the first request to redirect_pc is issued the cycle after redirect (when no response is outstanding). Otherwise it is issued the cycle after the old response returns.
- Reset mid-transaction: all state is cleared. A late im_rvalid after reset is ignored (outstanding=0).

## Configuration
- Macro IFU_BYPASS_EN.
- Defined: when count=0, drop=0 and im_rvalid=1, instr_valid/instr/instr_pc are driven combinationally from im_rdata/req_pc in the same cycle.
  - If instr_ready=1 in that cycle, the word is consumed and not enqueued.
  - If instr_ready=0, it is enqueued as normal.
  - Redirect still suppresses the bypass.
- Undefined: no combinational path from im_rvalid/im_rdata to the instr* outputs; minimum latency is 1 cycle.

## Test plan
- Reset, then grant immediately with a 1-cycle response and instr_ready=1:
  - im_addr sequence is 0x00400000, 0x00400004, 0x00400008.
  - instr_pc matches each word, in order.
- instr_ready=0 and memory always responding:
  - After 4 pushes, count=4 and im_req stays 0.
  - Raising instr_ready drains the words in order and fetch resumes at 0x00400010.
- Redirect to 0x00400103 while a request is outstanding:
  - The returning stale word is dropped.
  - The next im_addr is 0x00400100.
  - No stale instr_pc appears on the output.
- Redirect in the same cycle as im_rvalid, with a pop pending:
  - Queue is empty next cycle and the response is discarded.
  - instr_valid=0 until the new fetch returns.
- Assert rst mid-fetch, then a spurious im_rvalid:
  - Outputs return to reset values and nothing is enqueued.
  - im_addr=0x00400000.
- With IFU_BYPASS_EN, empty queue, instr_ready=1, and im_rvalid carrying 0x8C080004 at PC 0x00400000:
  - instr=0x8C080004 and instr_valid=1 in the same cycle.
  - count stays 0.
